// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide controller: op codes, FSM states, ALU controls.
// Define MDU_SIGNED_EN to compile in the FIX state used by signed MULT/DIV.
package mdu_pkg;

    localparam logic [2:0] MDU_MULTU = 3'b000;
    localparam logic [2:0] MDU_DIVU  = 3'b001;
    localparam logic [2:0] MDU_MULT  = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    // Must match the core's ALU control encoding.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;

`ifdef MDU_SIGNED_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
    } mdu_state_e;
`endif

    function automatic logic mdu_is_iter(input logic [2:0] op);
        return op[2] == 1'b0;
    endfunction

endpackage

// File: rtl/mdu_addsub.sv
// Shared DW-bit adder/subtractor for the MDU; cy is carry-out on add, borrow on subtract.
module mdu_addsub
    import mdu_pkg::*;
#(
    parameter int unsigned DW = 33
) (
    input  logic [3:0]    alu_op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y,
    output logic          cy
);

    logic [DW:0] ext;

    always_comb begin
        ext = '0;
        y   = '0;
        cy  = 1'b0;
        case (alu_op)
            ALU_SUB: begin
                ext = {1'b0, a} + {1'b0, ~b} + (DW + 1)'(1);
                y   = ext[DW-1:0];
                cy  = ~ext[DW];
            end
            ALU_OR: begin
                y = a | b;
            end
            default: begin
                ext = {1'b0, a} + {1'b0, b};
                y   = ext[DW-1:0];
                cy  = ext[DW];
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide controller owning HI/LO; one shared add/sub unit, WIDTH iterations.
// Signed MULT/DIV (with a trailing FIX cycle) are compiled in only when MDU_SIGNED_EN is defined.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned     CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef MDU_SIGNED_EN
    logic             fix_q, fix_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
`endif

    logic [3:0]       alu_op;
    logic [WIDTH:0]   alu_a, alu_b, alu_y;
    logic             alu_cy;
    logic [WIDTH:0]   div_rs;
    logic [WIDTH:0]   mul_t;

    mdu_addsub #(.DW(WIDTH + 1)) u_addsub (
        .alu_op (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .y      (alu_y),
        .cy     (alu_cy)
    );

`ifdef MDU_SIGNED_EN
    always_comb begin
        a_neg = A[WIDTH-1];
        b_neg = B[WIDTH-1];
        a_mag = a_neg ? ('0 - A) : A;
        b_mag = b_neg ? ('0 - B) : B;
    end
`endif

    // Operand steering for the shared unit: P+B for MUL, shifted R-B for DIV, 0-Q in FIX.
    always_comb begin
        div_rs = {acc_hi_q, acc_lo_q[WIDTH-1]};
        alu_op = ALU_ADD;
        alu_a  = {1'b0, acc_hi_q};
        alu_b  = {1'b0, b_q};
        if (is_div_q) begin
            alu_op = ALU_SUB;
            alu_a  = div_rs;
        end
`ifdef MDU_SIGNED_EN
        if (state_q == ST_FIX) begin
            alu_op = ALU_SUB;
            alu_a  = '0;
            alu_b  = {1'b0, acc_lo_q};
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef MDU_SIGNED_EN
        fix_d    = fix_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
`endif
        mul_t    = acc_lo_q[0] ? alu_y : {1'b0, acc_hi_q};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op == MDU_MTHI) begin
                        hi_d = A;
                    end else if (op == MDU_MTLO) begin
                        lo_d = A;
                    end else if (mdu_is_iter(op)) begin
                        state_d  = ST_RUN;
                        busy_d   = 1'b1;
                        count_d  = '0;
                        acc_hi_d = '0;
                        acc_lo_d = A;
                        b_d      = B;
                        is_div_d = op[0];
`ifdef MDU_SIGNED_EN
                        fix_d    = op[1];
                        neg_lo_d = 1'b0;
                        neg_hi_d = 1'b0;
                        if (op[1]) begin
                            acc_lo_d = a_mag;
                            b_d      = b_mag;
                            // Divide by zero keeps the natural quotient; only R regains A's sign.
                            neg_lo_d = (a_neg ^ b_neg) && (B != '0);
                            neg_hi_d = op[0] ? a_neg : (a_neg ^ b_neg);
                        end
`endif
                    end
                end
            end

            ST_RUN: begin
                count_d = count_q + CNT_W'(1);
                if (is_div_q) begin
                    acc_hi_d = alu_cy ? div_rs[WIDTH-1:0] : alu_y[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], ~alu_cy};
                end else begin
                    acc_hi_d = mul_t[WIDTH:1];
                    acc_lo_d = {mul_t[0], acc_lo_q[WIDTH-1:1]};
                end
                if (count_q == LAST) begin
                    count_d = '0;
`ifdef MDU_SIGNED_EN
                    if (fix_q) begin
                        state_d = ST_FIX;
                    end else
`endif
                    begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        hi_d    = acc_hi_d;
                        lo_d    = acc_lo_d;
                    end
                end
            end

`ifdef MDU_SIGNED_EN
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                lo_d    = neg_lo_q ? alu_y[WIDTH-1:0] : acc_lo_q;
                // 2W-bit product negation: HI absorbs the +1 only when LO was zero (no borrow).
                if (!neg_hi_q) begin
                    hi_d = acc_hi_q;
                end else if (is_div_q) begin
                    hi_d = '0 - acc_hi_q;
                end else begin
                    hi_d = ~acc_hi_q + WIDTH'(~alu_cy);
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MDU_SIGNED_EN
            fix_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MDU_SIGNED_EN
            fix_q    <= fix_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected {hi,lo}; a monitor pops on each done pulse.
module tb_mdu_ctrl;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] A, B;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2*W-1:0] exp_q[$];
    string          name_q[$];
    logic [W-1:0]   model_hi, model_lo;

    mdu_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 required done=0 (hi=%h lo=%h)", hi, lo);
            end else begin
                check(name_q.pop_front(), {hi, lo}, exp_q.pop_front());
            end
            check("done_busy_excl", (2*W)'(busy), (2*W)'(0));
        end
    end

    task automatic launch(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_busy(output int cnt, output bit moved);
        cnt   = 0;
        moved = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            cnt++;
            if (hi !== model_hi || lo !== model_lo) moved = 1'b1;
        end
    endtask

    task automatic run(input string name, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input int cyc);
        int cnt;
        bit moved;
        exp_q.push_back({eh, el});
        name_q.push_back(name);
        launch(o, a, b);
        wait_busy(cnt, moved);
        check({name, "_busy_cycles"}, (2*W)'(cnt), (2*W)'(cyc));
        check({name, "_hilo_stable"}, (2*W)'(moved), (2*W)'(0));
        model_hi = eh;
        model_lo = el;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cnt;
        bit  moved;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        A     = '0;
        B     = '0;
        model_hi = '0;
        model_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_hilo", {hi, lo}, '0);
        check("reset_busy_done", (2*W)'({busy, done}), (2*W)'(0));

        run("multu_max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32);
        @(negedge clk);
        run("divu_100_7", 3'b001, 32'd100, 32'd7, 32'd2, 32'd14, 32);
        @(negedge clk);
        run("divu_by_zero", 3'b001, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 32);
        @(negedge clk);

        launch(3'b100, 32'hDEAD_BEEF, 32'h0);
        @(negedge clk);
        model_hi = 32'hDEAD_BEEF;
        check("mthi_value", {hi, lo}, {32'hDEAD_BEEF, 32'hFFFF_FFFF});
        check("mthi_no_busy_done", (2*W)'({busy, done}), (2*W)'(0));

        exp_q.push_back({32'd2, 32'd14});
        name_q.push_back("divu_mtlo_ignored");
        launch(3'b001, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        start = 1'b1;
        op    = 3'b101;
        A     = 32'h5555_5555;
        @(negedge clk);
        start = 1'b0;
        wait_busy(cnt, moved);
        check("divu_mtlo_busy_cycles", (2*W)'(cnt + 4), (2*W)'(32));
        check("divu_mtlo_hilo_stable", (2*W)'(moved), (2*W)'(0));
        model_hi = 32'd2;
        model_lo = 32'd14;
        @(negedge clk);

        launch(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        model_hi = '0;
        model_lo = '0;
        check("midop_reset_hilo", {hi, lo}, '0);
        check("midop_reset_busy_done", (2*W)'({busy, done}), (2*W)'(0));
        run("multu_3x5", 3'b000, 32'd3, 32'd5, 32'd0, 32'd15, 32);
        @(negedge clk);

        run("b2b_first_multu", 3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0, 32);
        run("b2b_second_divu", 3'b001, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 32);
        @(negedge clk);

        launch(3'b110, 32'h1, 32'h2);
        @(negedge clk);
        check("op110_hilo", {hi, lo}, {32'hF, 32'h0FFF_FFFF});
        check("op110_busy", (2*W)'(busy), (2*W)'(0));
        launch(3'b111, 32'h3, 32'h4);
        @(negedge clk);
        check("op111_hilo", {hi, lo}, {32'hF, 32'h0FFF_FFFF});

`ifdef MDU_SIGNED_EN
        run("div_m7_2", 3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        @(negedge clk);
        run("mult_m2_3", 3'b010, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 33);
        @(negedge clk);
        run("div_m5_by_zero", 3'b011, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33);
        @(negedge clk);
`else
        run("op011_as_divu", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 32);
        @(negedge clk);
        run("op010_as_multu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 32);
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_drained", (2*W)'(exp_q.size()), (2*W)'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller for the pipelined MIPS core. It sequences one shared 32-bit add/sub unit over 32 iterations to implement MULTU/DIVU, plus MULT/DIV when signed support is compiled in. It owns the architectural HI/LO registers and exposes a start/busy/done handshake to the EX stage. MTHI/MTLO write HI/LO directly.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; iteration count equals `WIDTH`.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request; sampled only in IDLE.
- `op` input 3: 000 MULTU, 001 DIVU, 010 MULT, 011 DIV, 100 MTHI, 101 MTLO; 110/111 are ignored.
- `A` input WIDTH: multiplicand, dividend, or MTHI/MTLO data.
- `B` input WIDTH: multiplier or divisor.
- `busy` output 1: high while an iterative op is in flight.
- `done` output 1: one-cycle pulse after HI/LO update.
- `hi` output WIDTH: architectural HI.
- `lo` output WIDTH: architectural LO.

## Operation
- States: IDLE, RUN, FIX (FIX exists only with the macro).
- **IDLE, `start`=1:**
  - MULTU/DIVU/MULT/DIV latch the operands, set count=0 and go to RUN.
  - MTHI/MTLO write `hi`/`lo` from `A` at that edge and stay in IDLE. No busy, no done.
  - Ops 110/111 have no effect.
- **IDLE, `start`=0:** no effect.
- **MUL iteration** (accumulator acc:{P,Q}, Q initialised to A, P=0):
  - If Q[0], the add/sub unit computes P+B with carry-out, forming a WIDTH+1 sum.
  - {carry,sum,Q} shifts right by 1.
- **DIV iteration** (R=0, Q=A):
  - Shift {R,Q} left by 1.
  - The add/sub unit computes R−B as a WIDTH+1 difference.
  - No borrow: R = difference, Q[0] = 1. Borrow: R unchanged, Q[0] = 0.
- **Completion:** after iteration count reaches WIDTH−1, go to IDLE (or FIX when signed) and write `hi`=P/R, `lo`=Q.
- **Divide by zero:** no trap; the result is `lo`=all ones, `hi`=A (natural restoring result).
- **Start while busy:** `start` in RUN/FIX is ignored, including MTHI/MTLO; the pipeline stalls on `busy`.
- **HI/LO visibility:** `hi`/`lo` hold previous values for the whole operation. Only the completion edge changes them.
- **Reset, any state including mid-operation:** state IDLE, count=0, `hi`=`lo`=0, `busy`=0, `done`=0. Partial results are discarded.

## Timing
- Start accepted at edge E0: `busy`=1 from E0 through E32, i.e. 32 cycles for WIDTH=32.
- Unsigned ops: `hi`/`lo` written at E32; `busy` falls and `done`=1 during the cycle after E32. Total latency 32 cycles.
- Signed ops (macro on): FIX occupies one extra cycle. Results are written at E33, `busy` spans 33 cycles, and `done` is asserted after E33.
- MTHI/MTLO: value visible the cycle after the accepting edge.
- A new `start` is accepted in the same cycle `done` is high (state is IDLE).
- `done` is registered: it is never high in a cycle where `busy` is high.

## Configuration
- **`MDU_SIGNED_EN` defined:**
  - At start, MULT/DIV take operand magnitudes and record sign flags.
  - In FIX, the add/sub unit negates results:
    - Product negated if the operand signs differ.
    - Quotient negated if the signs differ.
    - Remainder takes the dividend's sign.
  - Signed divide by zero: `lo`=all ones, `hi`=A.
- **Undefined:** no FIX state and no sign logic. Op 010 behaves exactly as 000 and op 011 exactly as 001.

## Structure
- **Package `mdu_pkg`:**
  - op encodings (`MDU_MULTU` … `MDU_MTLO`).
  - state enum.
  - ALU operation codes `ALU_ADD`=4'b0000, `ALU_SUB`=4'b0001, `ALU_OR`=4'b0010, matching the core's ALU control encoding.
- **Sub-module `mdu_addsub`:**
  - WIDTH+1-bit adder/subtractor selected by `ALU_ADD`/`ALU_SUB`.
  - Outputs the sum/difference and the carry/borrow.
  - Instantiated once and shared by the MUL iteration, the DIV iteration and FIX.

## Test plan
- **MULTU:** A=B=0xFFFF_FFFF → `busy` high exactly 32 cycles, then `hi`=0xFFFF_FFFE, `lo`=0x0000_0001, single `done` pulse.
- **DIVU:** A=100, B=7 → `lo`=14, `hi`=2. Then A=0x1234, B=0 → `lo`=0xFFFF_FFFF, `hi`=0x1234.
- **MTHI and start-while-busy:**
  - MTHI A=0xDEADBEEF in IDLE → `hi`=0xDEADBEEF the next cycle, `lo` unchanged, `busy`/`done` stay 0.
  - MTLO issued during a DIVU → ignored; `lo` ends as the DIVU quotient.
- **Reset mid-operation:** assert `reset` at cycle 10 of MULTU → next cycle `hi`=`lo`=0, `busy`=0, no `done`. A following MULTU 3×5 → `lo`=15, `hi`=0.
- **Back-to-back:** new start in the `done` cycle is accepted and its `busy` begins at that edge. Also check HI/LO stay stable during RUN.
- **Signed (`MDU_SIGNED_EN`):**
  - DIV −7/2 → `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF, 33-cycle `busy`.
  - MULT −2×3 → `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFFA.
  - Without the macro, op 011 with A=100, B=7 gives the DIVU result.
